// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - framed MSB-first "1011" scanner; SEQ_CNT_SAT_EN selects a saturating match_count
module seq_scan_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {S0, S1, S10, S101, S1011} det_t;

    state_t           state_q, state_d;
    det_t             det_q, det_d, det_step;
    logic [W-1:0]     data_q, data_d;
    logic             last_q, last_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             accept;
    logic             cur_bit;

    assign cur_bit = data_q[W-1];

`ifdef SEQ_CNT_SAT_EN
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`else
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    always_comb begin
        det_step = det_q;
        case (det_q)
            S0:      det_step = cur_bit ? S1    : S0;
            S1:      det_step = cur_bit ? S1    : S10;
            S10:     det_step = cur_bit ? S101  : S0;
            S101:    det_step = cur_bit ? S1011 : S10;
            S1011:   det_step = cur_bit ? S1    : S10;
            default: det_step = S0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        data_d   = data_q;
        last_d   = last_q;
        bit_d    = bit_q;
        busy_d   = busy_q;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q;
        in_ready = (state_q == IDLE);
        accept   = in_valid & in_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                    // Detector history only survives between words of the same frame
                    if (!busy_q) begin
                        det_d = S0;
                        cnt_d = '0;
                    end
                end
            end
            SHIFT: begin
                det_d  = det_step;
                data_d = {data_q[W-2:0], 1'b0};
                bit_d  = bit_q + BW'(1);
                if (det_step == S1011) begin
                    pulse_d = 1'b1;
                    cnt_d   = cnt_inc;
                end
                if (bit_q == BW'(W - 1)) begin
                    bit_d = '0;
                    if (last_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            det_q   <= S0;
            data_q  <= '0;
            last_q  <= 1'b0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            data_q  <= data_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match_pulse = pulse_q;
    assign match_count = cnt_q;
    assign busy        = busy_q;
    assign done        = (state_q == DONE);

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: input word width in bits, W >= 4.
REQ-002 SHALL have parameter CNT_W, default 8: width of match_count.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: in_data/in_last are valid.
REQ-006 SHALL have port in_ready  output  1: block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  W: word to scan, MSB first.
REQ-008 SHALL have port in_last  input  1: accepted word ends the current frame.
REQ-009 SHALL have port match_pulse  output  1: one-cycle strobe per detected "1011".
REQ-010 SHALL have port match_count  output  CNT_W: matches in the current or most recent frame.
REQ-011 SHALL have port busy  output  1: a frame is open.
REQ-012 SHALL have port done  output  1: one-cycle strobe at frame end.

Function
REQ-013 SHALL implement a controller FSM with states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; a word is accepted on an edge with in_valid & in_ready, else in_data is ignored.
REQ-015 SHALL latch in_data/in_last on accept, then go IDLE->SHIFT.
REQ-016 SHALL stay in SHIFT exactly W cycles, presenting one bit per cycle to the embedded detector, from in_data[W-1] down to in_data[0].
REQ-017 SHALL, after the W-th shift cycle, go to DONE if the latched in_last=1, else return to IDLE with the frame still open.
REQ-018 SHALL hold DONE one cycle with done=1, then go to IDLE; busy SHALL fall in the same cycle.
REQ-019 SHALL embed an overlapping Moore "1011" detector with states S0, S1, S10, S101, S1011, advancing only in SHIFT cycles and holding its state otherwise.
REQ-020 SHALL use these detector transitions (bit 0 / bit 1): S0->S0/S1; S1->S10/S1; S10->S0/S101; S101->S10/S1011; S1011->S10/S1.
REQ-021 SHALL carry detector state across IDLE gap cycles within a frame, so patterns spanning word boundaries are detected.
REQ-022 SHALL reset the detector to S0 and match_count to 0 on the accept edge of the first word of a frame, when busy=0.
REQ-023 SHALL, on each edge where the detector enters S1011, assert match_pulse for the following cycle and increment match_count at that same edge.
REQ-024 SHALL make match_pulse for the 4th pattern bit, shifted in cycle c, visible in cycle c+1, so the final count is stable when done=1.
REQ-025 SHALL set busy=1 from the first accept edge of a frame until the DONE cycle.
REQ-026 SHALL hold match_count after done until the next frame starts.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, detector=S0, in_ready=1 after release, match_pulse=0, match_count=0, busy=0, done=0, and discard any partially shifted word.
REQ-028 SHALL deassert rst synchronously to clk; the first accept is possible in the first cycle after deassertion.

Configuration
REQ-029 SHALL, with macro SEQ_CNT_SAT_EN defined, saturate match_count at 2^CNT_W-1; match_pulse still fires on every detection.
REQ-030 SHALL, without SEQ_CNT_SAT_EN, let match_count wrap modulo 2^CNT_W.

Verification
REQ-031 SHALL cover the single match case: W=8, word 8'b1011_0000 with in_last=1 accepted at edge k -> match_pulse high in cycle k+5 only, done in cycle k+9, match_count=1.
REQ-032 SHALL cover overlap: word 8'b1011_0110 with in_last=1 -> two match_pulses, 3 cycles apart, final match_count=2.
REQ-033 SHALL cover a cross-word match: 8'b0000_0010 with last=0, one idle gap cycle, then 8'b1100_0000 with last=1 -> match_count=1, busy=1 across the gap.
REQ-034 SHALL cover backpressure: in_valid held high during SHIFT -> in_ready=0, and each word is consumed exactly once.
REQ-035 SHALL cover the counter limit: CNT_W=2, three words 8'b1011_0110 (6 matches) -> match_count=3 with SEQ_CNT_SAT_EN, 2 without.
REQ-036 SHALL cover reset mid-operation: rst=0 during the 3rd SHIFT cycle -> all outputs at reset values immediately; a fresh frame afterwards counts from 0.
